// File: rtl/raw_data_pkg.sv
// Shared types and the round-robin pick function used by the raw-data arbiter
// and by any later multi-queue block that needs the same priority rotation.
package raw_data_pkg;

    localparam int RAW_DATA_W = 64;
    localparam int RR_MAX_SRC = 16;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        FETCH,
        READY,
        HOLD
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping modulo n (n <= RR_MAX_SRC).
    // Walk the offsets from the far end so the nearest hit overwrites the others.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                         input logic [3:0]            ptr,
                                         input int                    n);
        rr_pick_t   r;
        int         i;
        logic [3:0] i4;
        r = '0;
        for (int off = RR_MAX_SRC - 1; off >= 0; off--) begin
            if (off < n) begin
                i = int'(ptr) + off;
                if (i >= n) i = i - n;
                i4 = 4'(i);
                if (req[i4]) begin
                    r.found = 1'b1;
                    r.idx   = i4;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin priority picker: lowest requesting index at or
// after ptr_i, wrapping at NUM_SRC-1 (NUM_SRC need not be a power of two).
module rr_pick_comb
    import raw_data_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [SRC_W-1:0]   idx_o,
    output logic               found_o
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_pick(RR_MAX_SRC'(req_i), 4'(ptr_i), NUM_SRC);
    end

    assign idx_o   = SRC_W'(pick.idx);
    assign found_o = pick.found;

endmodule

// File: rtl/raw_data_arbiter.sv
// Per-message round-robin arbiter feeding one serializer from NUM_SRC raw-data
// FIFOs; a grant is held until the last-tagged word of the message is accepted.
module raw_data_arbiter
    import raw_data_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = RAW_DATA_W,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        fifo_empty,
    input  logic [NUM_SRC*DATA_W-1:0] fifo_data,
    input  logic [NUM_SRC-1:0]        fifo_last,
    output logic [NUM_SRC-1:0]        fifo_pop,
    output logic [DATA_W-1:0]         raw_data,
    output logic                      raw_data_last,
    output logic [SRC_W-1:0]          raw_data_src,
    output logic                      raw_data_valid,
    input  logic                      raw_data_accepted,
    output logic                      busy
);

    arb_state_e        state_q;
    logic [SRC_W-1:0]  rr_ptr_q;
    logic [SRC_W-1:0]  grant_q;
    logic [DATA_W-1:0] raw_data_q;
    logic              raw_last_q;
    logic [SRC_W-1:0]  raw_src_q;
    logic              raw_valid_q;
    logic [SRC_W-1:0]  pick_idx;
    logic              pick_found;
    logic [SRC_W-1:0]  rr_ptr_d;

    rr_pick_comb #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req_i   (~fifo_empty),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Explicit wrap so non-power-of-two NUM_SRC never points past the last source.
    assign rr_ptr_d = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            raw_data_q  <= '0;
            raw_last_q  <= 1'b0;
            raw_src_q   <= '0;
            raw_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= POP;
                    end
                end
                POP: state_q <= FETCH;
                FETCH: begin
                    raw_data_q  <= fifo_data[int'(grant_q)*DATA_W +: DATA_W];
                    raw_last_q  <= fifo_last[grant_q];
                    raw_src_q   <= grant_q;
                    raw_valid_q <= 1'b1;
                    state_q     <= READY;
                end
                READY: begin
                    if (raw_data_accepted) begin
                        raw_valid_q <= 1'b0;
                        if (raw_last_q) begin
                            rr_ptr_q <= rr_ptr_d;
                            state_q  <= IDLE;
                        end else if (!fifo_empty[grant_q]) begin
                            state_q <= POP;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                // Mid-message stall: other requesters wait, the grant stays put.
                HOLD: begin
                    if (!fifo_empty[grant_q]) state_q <= POP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_pop = '0;
        if (state_q == POP) fifo_pop[grant_q] = 1'b1;
    end

    assign raw_data       = raw_data_q;
    assign raw_data_last  = raw_last_q;
    assign raw_data_src   = raw_src_q;
    assign raw_data_valid = raw_valid_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_raw_data_arbiter.sv
// Bench for raw_data_arbiter: queue-modelled FIFOs, a message-level round-robin
// reference stream, and directed plus randomized scenarios.
module tb_raw_data_arbiter;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int SW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct packed {
        logic [3:0]    src;
        logic [DW-1:0] data;
        logic          last;
    } xact_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NS-1:0]    fifo_empty = '1;
    logic [NS*DW-1:0] fifo_data = '0;
    logic [NS-1:0]    fifo_last = '0;
    logic [NS-1:0]    fifo_pop;
    logic [DW-1:0]    raw_data;
    logic             raw_data_last;
    logic [SW-1:0]    raw_data_src;
    logic             raw_data_valid;
    logic             raw_data_accepted = 1'b0;
    logic             busy;

    word_t         fq[NS][$];
    xact_t         obs[$];
    xact_t         exp_q[$];
    logic [NS-1:0] pop_log[$];
    int            nchk = 0;
    int            nerr = 0;

    always #5 clk = ~clk;

    raw_data_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .SRC_W(SW)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_empty        (fifo_empty),
        .fifo_data         (fifo_data),
        .fifo_last         (fifo_last),
        .fifo_pop          (fifo_pop),
        .raw_data          (raw_data),
        .raw_data_last     (raw_data_last),
        .raw_data_src      (raw_data_src),
        .raw_data_valid    (raw_data_valid),
        .raw_data_accepted (raw_data_accepted),
        .busy              (busy)
    );

    // FIFO model (registered read: data ready for the edge after the pop)
    // and monitor of accepted words.
    always @(negedge clk) begin
        word_t w;
        if (fifo_pop !== '0) begin
            pop_log.push_back(fifo_pop);
            nchk++;
            if ($countones(fifo_pop) != 1) begin
                nerr++;
                $display("FAIL pop_onehot: got %b want one-hot", fifo_pop);
            end
            for (int i = 0; i < NS; i++) begin
                if (fifo_pop[i] && fq[i].size() > 0) begin
                    w = fq[i].pop_front();
                    fifo_data[i*DW +: DW] = w.data;
                    fifo_last[i]          = w.last;
                end
            end
        end
        if (raw_data_valid && raw_data_accepted)
            obs.push_back('{src: 4'(raw_data_src), data: raw_data, last: raw_data_last});
        for (int i = 0; i < NS; i++) fifo_empty[i] = (fq[i].size() == 0);
    end

    task automatic push_word(input int s, input logic [DW-1:0] d, input logic l);
        fq[s].push_back('{data: d, last: l});
    endtask

    // Reference: whole messages granted round-robin starting at start_ptr.
    task automatic build_expected(input int start_ptr);
        word_t mq[NS][$];
        word_t w;
        int    p;
        int    sel;
        bit    any;
        p = start_ptr;
        for (int i = 0; i < NS; i++) mq[i] = fq[i];
        exp_q.delete();
        while (1) begin
            any = 0;
            sel = 0;
            for (int k = 0; k < NS; k++) begin
                if (!any && mq[(p + k) % NS].size() > 0) begin
                    any = 1;
                    sel = (p + k) % NS;
                end
            end
            if (!any) break;
            do begin
                w = mq[sel].pop_front();
                exp_q.push_back('{src: 4'(sel), data: w.data, last: w.last});
            end while (!w.last && mq[sel].size() > 0);
            p = (sel + 1) % NS;
        end
    endtask

    task automatic wait_obs(input int n, input int budget, input bit rnd);
        int c;
        c = 0;
        while (obs.size() < n && c < budget) begin
            @(posedge clk); #1;
            if (rnd) raw_data_accepted = 1'($urandom_range(0, 1));
            c++;
        end
        if (obs.size() < n) begin
            nchk++;
            nerr++;
            $display("FAIL wait_obs: got %0d words want %0d", obs.size(), n);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        raw_data_accepted = 1'b0;
        for (int i = 0; i < NS; i++) fq[i].delete();
        obs.delete();
        pop_log.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        nchk++;
        if ({fifo_pop, raw_data, raw_data_last, raw_data_src, raw_data_valid, busy} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got pop=%b data=%h last=%b src=%0d valid=%b busy=%b want all 0",
                     fifo_pop, raw_data, raw_data_last, raw_data_src, raw_data_valid, busy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            nchk++;
            if (raw_data_valid !== 1'b0 || busy !== 1'b0 || fifo_pop !== '0) begin
                nerr++;
                $display("FAIL idle_empty: cycle %0d got valid=%b busy=%b pop=%b want 0/0/0",
                         c, raw_data_valid, busy, fifo_pop);
            end
        end
    endtask

    task automatic test_single();
        int k;
        apply_reset();
        raw_data_accepted = 1'b1;
        push_word(2, 64'hA5, 1'b1);
        k = 0;
        while (!raw_data_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        nchk++;
        if (k != 3) begin
            nerr++;
            $display("FAIL single_latency: got %0d edges want 3", k);
        end
        nchk++;
        if (raw_data !== 64'hA5 || raw_data_src !== 2'd2 || raw_data_last !== 1'b1) begin
            nerr++;
            $display("FAIL single_word: got data=%h src=%0d last=%b want a5/2/1",
                     raw_data, raw_data_src, raw_data_last);
        end
        repeat (4) @(posedge clk);
        #1;
        nchk++;
        if (pop_log.size() != 1 || pop_log[0] !== 4'b0100) begin
            nerr++;
            $display("FAIL single_pop: got %0d pops first=%b want 1 pop 0100",
                     pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 4'b0);
        end
        nchk++;
        if (busy !== 1'b0 || obs.size() != 1) begin
            nerr++;
            $display("FAIL single_done: got busy=%b words=%0d want 0/1", busy, obs.size());
        end
        // Pointer now sits at 3: src 3 must win over src 0.
        push_word(0, 64'h11, 1'b1);
        push_word(3, 64'h33, 1'b1);
        wait_obs(3, 40, 0);
        nchk++;
        if (obs.size() < 3 || obs[1].src !== 4'd3 || obs[2].src !== 4'd0) begin
            nerr++;
            $display("FAIL rr_ptr_after_src2: got %0d words want order 3 then 0", obs.size());
        end
    endtask

    task automatic test_all_sources();
        apply_reset();
        raw_data_accepted = 1'b1;
        for (int s = 0; s < NS; s++) push_word(s, {$urandom, $urandom}, 1'b1);
        build_expected(0);
        wait_obs(exp_q.size(), 100, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            nchk++;
            if (k >= obs.size() || obs[k] !== exp_q[k]) begin
                nerr++;
                $display("FAIL all_src_word%0d: got %h want %h", k,
                         (k < obs.size()) ? obs[k] : '0, exp_q[k]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        nchk++;
        if (pop_log.size() != 4 || pop_log[0] !== 4'b0001 || pop_log[1] !== 4'b0010 ||
            pop_log[2] !== 4'b0100 || pop_log[3] !== 4'b1000) begin
            nerr++;
            $display("FAIL all_src_pops: got %0d pops want 4 in order 0,1,2,3", pop_log.size());
        end
    endtask

    task automatic test_hold();
        logic [DW-1:0] d1, d2, d3, e1;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        d3 = {$urandom, $urandom};
        e1 = {$urandom, $urandom};
        apply_reset();
        raw_data_accepted = 1'b1;
        push_word(0, d1, 1'b0);
        push_word(1, e1, 1'b1);
        wait_obs(1, 20, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            nchk++;
            if (busy !== 1'b1 || raw_data_valid !== 1'b0 || pop_log.size() != 1) begin
                nerr++;
                $display("FAIL hold_locked: cycle %0d got busy=%b valid=%b pops=%0d want 1/0/1",
                         c, busy, raw_data_valid, pop_log.size());
            end
        end
        push_word(0, d2, 1'b0);
        push_word(0, d3, 1'b1);
        exp_q.delete();
        exp_q.push_back('{src: 4'd0, data: d1, last: 1'b0});
        exp_q.push_back('{src: 4'd0, data: d2, last: 1'b0});
        exp_q.push_back('{src: 4'd0, data: d3, last: 1'b1});
        exp_q.push_back('{src: 4'd1, data: e1, last: 1'b1});
        wait_obs(4, 60, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            nchk++;
            if (k >= obs.size() || obs[k] !== exp_q[k]) begin
                nerr++;
                $display("FAIL hold_word%0d: got %h want %h", k,
                         (k < obs.size()) ? obs[k] : '0, exp_q[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d1, d2, sd;
        logic          sl;
        logic [SW-1:0] ss;
        int            pops, k;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        apply_reset();
        push_word(1, d1, 1'b0);
        push_word(1, d2, 1'b1);
        k = 0;
        while (!raw_data_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        sd = raw_data;
        sl = raw_data_last;
        ss = raw_data_src;
        pops = pop_log.size();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            nchk++;
            if (raw_data_valid !== 1'b1 || raw_data !== sd || raw_data_last !== sl ||
                raw_data_src !== ss || pop_log.size() != pops) begin
                nerr++;
                $display("FAIL stall_stable: cycle %0d got valid=%b data=%h pops=%0d want 1/%h/%0d",
                         c, raw_data_valid, raw_data, pop_log.size(), sd, pops);
            end
        end
        raw_data_accepted = 1'b1;
        @(posedge clk); #1;
        nchk++;
        if (raw_data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL stall_release: got valid=%b want 0", raw_data_valid);
        end
        exp_q.delete();
        exp_q.push_back('{src: 4'd1, data: d1, last: 1'b0});
        exp_q.push_back('{src: 4'd1, data: d2, last: 1'b1});
        wait_obs(2, 30, 0);
        for (int j = 0; j < exp_q.size(); j++) begin
            nchk++;
            if (j >= obs.size() || obs[j] !== exp_q[j]) begin
                nerr++;
                $display("FAIL stall_word%0d: got %h want %h", j,
                         (j < obs.size()) ? obs[j] : '0, exp_q[j]);
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        apply_reset();
        raw_data_accepted = 1'b1;
        push_word(1, 64'h1, 1'b1);
        wait_obs(1, 20, 0);
        repeat (3) @(posedge clk);
        #1;
        raw_data_accepted = 1'b0;
        push_word(3, 64'h30, 1'b0);
        push_word(3, 64'h31, 1'b1);
        k = 0;
        while (!raw_data_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        nchk++;
        if (raw_data_valid !== 1'b0 || fifo_pop !== '0 || busy !== 1'b0 || raw_data !== '0) begin
            nerr++;
            $display("FAIL async_reset: got valid=%b pop=%b busy=%b data=%h want all 0",
                     raw_data_valid, fifo_pop, busy, raw_data);
        end
        for (int i = 0; i < NS; i++) fq[i].delete();
        obs.delete();
        pop_log.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        raw_data_accepted = 1'b1;
        push_word(2, 64'h22, 1'b1);
        push_word(0, 64'h20, 1'b1);
        build_expected(0);
        wait_obs(exp_q.size(), 40, 0);
        for (int j = 0; j < exp_q.size(); j++) begin
            nchk++;
            if (j >= obs.size() || obs[j] !== exp_q[j]) begin
                nerr++;
                $display("FAIL post_reset_word%0d: got %h want %h", j,
                         (j < obs.size()) ? obs[j] : '0, exp_q[j]);
            end
        end
    endtask

    task automatic test_random();
        int nm, len;
        for (int it = 0; it < 3; it++) begin
            apply_reset();
            for (int s = 0; s < NS; s++) begin
                nm = int'($urandom_range(0, 3));
                for (int m = 0; m < nm; m++) begin
                    len = int'($urandom_range(1, 3));
                    for (int w = 0; w < len; w++)
                        push_word(s, {$urandom, $urandom}, (w == len - 1));
                end
            end
            build_expected(0);
            wait_obs(exp_q.size(), 60 * exp_q.size() + 50, 1);
            raw_data_accepted = 1'b1;
            for (int k = 0; k < exp_q.size(); k++) begin
                nchk++;
                if (k >= obs.size() || obs[k] !== exp_q[k]) begin
                    nerr++;
                    $display("FAIL random_it%0d_word%0d: got %h want %h", it, k,
                             (k < obs.size()) ? obs[k] : '0, exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_sources();
        test_hold();
        test_stall();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/raw_data_arbiter.md
Name: raw_data_arbiter

Overview:
- Shares one protobuf serializer input between NUM_SRC raw-data FIFOs.
- Round-robin grant per message: a grant is held until the word tagged last-of-message is accepted, so messages never interleave.
- Pops the granted FIFO, registers the word, and presents it with valid until the serializer accepts it.
- Sits between the per-source raw-data output FIFOs and the serializer front end, in place of a single-source fetch FSM.

Parameters:
- NUM_SRC, 4, number of requesting FIFOs (2..16).
- DATA_W, 64, raw data word width.
- SRC_W, $clog2(NUM_SRC), width of the source index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low.
- fifo_empty  input  NUM_SRC  per-source FIFO empty flag.
- fifo_data  input  NUM_SRC*DATA_W  per-source read data; source i occupies bits [i*DATA_W +: DATA_W]. Registered read: valid the cycle after pop.
- fifo_last  input  NUM_SRC  per-source last-of-message tag, same timing as fifo_data.
- fifo_pop  output  NUM_SRC  one-hot pop strobe.
- raw_data  output  DATA_W  registered word to serializer.
- raw_data_last  output  1  registered last tag.
- raw_data_src  output  SRC_W  index of the granted source.
- raw_data_valid  output  1  word present.
- raw_data_accepted  input  1  serializer accepts the word this cycle; only meaningful while valid=1.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant=0.
  - fifo_pop=0, raw_data=0, raw_data_last=0, raw_data_src=0, raw_data_valid=0, busy=0.
- States: IDLE, POP, FETCH, READY, HOLD.
- IDLE:
  - req = ~fifo_empty. If req != 0, grant = first requesting index at or after rr_ptr (wrapping modulo NUM_SRC), then go to POP.
  - Otherwise stay in IDLE.
- POP:
  - fifo_pop[grant]=1 for exactly one cycle, then go to FETCH.
  - fifo_pop is a pure decode of (state==POP, grant); never more than one bit high.
- FETCH:
  - Capture fifo_data[grant], fifo_last[grant] and grant into raw_data, raw_data_last and raw_data_src.
  - Set raw_data_valid=1 at the same edge and go to READY.
- READY:
  - valid=1; raw_data, raw_data_last and raw_data_src are held stable until accepted.
  - On accepted with last=1: valid=0, rr_ptr=grant+1 (wrapping NUM_SRC-1 to 0), go to IDLE.
  - On accepted with last=0 and fifo_empty[grant]=0: valid=0, go to POP.
  - On accepted with last=0 and fifo_empty[grant]=1: valid=0, go to HOLD.
- HOLD:
  - Grant stays locked. Requests from other sources are ignored.
  - When fifo_empty[grant]=0, go to POP.
- Latency:
  - IDLE with a request to valid high: 3 edges.
  - Accept to next valid within the same message: 3 edges (READY to POP to FETCH to READY).
  - Minimum cycle is therefore 1 word per 3 cycles; this is intentional and must not be optimised away.
- Boundary conditions:
  - All sources requesting: strict rotation 0,1,2,3,0...
  - A source that empties mid-message retains the grant indefinitely.
  - accepted while valid=0 is ignored.
  - accepted in the same cycle valid rises: not possible, because valid is registered.
  - An empty flag dropping while in POP or FETCH is not re-checked; upstream guarantees pop only when non-empty.
  - NUM_SRC not a power of 2: rr_ptr wraps explicitly at NUM_SRC-1.
  - Reset mid-message: all state is discarded immediately; the partial message is the upstream's responsibility.

Decomposition:
- Shared package raw_data_pkg:
  - state enum (IDLE, POP, FETCH, READY, HOLD).
  - Default DATA_W.
  - Function rr_pick(req, ptr) returning the index and found flag.
- One sub-module, rr_pick_comb: combinational round-robin priority picker, parameterised on NUM_SRC. Reused by later multi-queue blocks.

Test Plan:
- Reset with all FIFOs empty -> all outputs 0, busy=0, stays IDLE for 10 cycles.
- Only src 2 non-empty, single word 0xA5 with last=1, accepted held high -> fifo_pop=4'b0100 for 1 cycle, valid 3 edges after req, raw_data=0xA5, raw_data_src=2, rr_ptr=3 afterwards.
- All four sources each holding one single-word message, accepted always 1 -> grant order 0,1,2,3; exactly 4 pops, each one-hot.
- Src 0 sends a 3-word message, src 1 requesting throughout, src 0 empty after word 1 for 5 cycles -> FSM sits in HOLD, no pop to src 1, words 2 and 3 from src 0 delivered before any src 1 word.
- valid high with accepted held 0 for 8 cycles -> raw_data, raw_data_last and raw_data_src stable, no further pop; accept on cycle 9 -> valid falls next edge.
- reset asserted asynchronously while in READY -> valid=0 and fifo_pop=0 immediately without waiting for a clock edge; after release, arbitration restarts at src 0.
